// File: rtl/pixel_scanout.sv
// pixel_scanout: programmable raster timing generator that composites a sparse pixel stream over a background colour.
// Define PIXSCAN_DROP_CNT_EN to enable the 16-bit saturating late/dropped pixel counter on drop_count.
module pixel_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic [COLOR_W-1:0] in_red,
  input  logic [COLOR_W-1:0] in_green,
  input  logic [COLOR_W-1:0] in_blue,
  input  logic [COLOR_W-1:0] bg_red,
  input  logic [COLOR_W-1:0] bg_green,
  input  logic [COLOR_W-1:0] bg_blue,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic [15:0]        drop_count
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = Y_W + X_W;
  localparam int EW = KW + 3 * COLOR_W;

  localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] H_LAST   = X_W'(HT - 1);
  localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] V_LAST   = Y_W'(VT - 1);

  logic [X_W-1:0] r_cx;
  logic [Y_W-1:0] r_cy;
  logic [EW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wr_ptr, r_rd_ptr;
  logic [COLOR_W-1:0] r_red, r_green, r_blue;
  logic r_de, r_hsync, r_vsync, r_frame_start;

  logic          w_empty, w_full, w_push, w_pop, w_show, w_active;
  logic [EW-1:0] w_head;
  logic [KW-1:0] w_head_key, w_pos_key;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  // in_ready is also gated by reset so the producer sees a closed FIFO for the whole reset window.
  assign in_ready   = !w_full && !reset;
  assign w_push     = in_valid && !w_full;

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_key = w_head[EW-1 -: KW];
  assign w_pos_key  = {r_cy, r_cx};
  assign w_active   = (r_cx < H_ACT_X) && (r_cy < V_ACT_Y);
  // Anything at or behind the scan position leaves the FIFO; only an exact active hit is shown.
  assign w_pop      = !w_empty && (w_head_key <= w_pos_key);
  assign w_show     = w_pop && (w_head_key == w_pos_key) && w_active;

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_cx == H_LAST) begin
      r_cx <= '0;
      r_cy <= (r_cy == V_LAST) ? '0 : r_cy + 1'b1;
    end else begin
      r_cx <= r_cx + 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge pixclk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {in_y, in_x, in_red, in_green, in_blue};
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      {r_red, r_green, r_blue} <= '0;
      r_de          <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_de          <= w_active;
      r_hsync       <= ((r_cx >= HS_START) && (r_cx < HS_END)) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= ((r_cy >= VS_START) && (r_cy < VS_END)) ? SYNC_POL : ~SYNC_POL;
      r_frame_start <= (r_cx == '0) && (r_cy == '0);
      if (w_show)
        {r_red, r_green, r_blue} <= w_head[3*COLOR_W-1:0];
      else if (w_active)
        {r_red, r_green, r_blue} <= {bg_red, bg_green, bg_blue};
      else
        {r_red, r_green, r_blue} <= '0;
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

`ifdef PIXSCAN_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_count;

  assign w_drop = w_pop && !w_show;

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset)
      r_drop_count <= '0;
    else if (w_drop && (r_drop_count != 16'hFFFF))
      r_drop_count <= r_drop_count + 1'b1;
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = '0;
`endif

endmodule
